// File: rtl/id_ex_stage_if.sv
// Bundle of the IF/ID, regfile, writeback and EX-side signals of the decode stage.
// The slave modport is the stage itself; the master modport is its surroundings.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     if_valid;
    logic                     if_ready;
    logic [31:0]              if_instr;
    logic [DATA_WIDTH-1:0]    if_pc;
    logic                     flush;

    logic [ADDRESS_WIDTH-1:0] ra1;
    logic [ADDRESS_WIDTH-1:0] ra2;
    logic [DATA_WIDTH-1:0]    rd1;
    logic [DATA_WIDTH-1:0]    rd2;

    logic                     wb_RegWrite;
    logic [ADDRESS_WIDTH-1:0] wb_wa;
    logic [DATA_WIDTH-1:0]    wb_wd;

    logic                     ex_ready;
    logic                     ex_valid;
    logic [DATA_WIDTH-1:0]    ex_pc;
    logic [DATA_WIDTH-1:0]    ex_rs1_data;
    logic [DATA_WIDTH-1:0]    ex_rs2_data;
    logic [DATA_WIDTH-1:0]    ex_imm;
    logic [ADDRESS_WIDTH-1:0] ex_rd;
    logic [6:0]               ex_opcode;
    logic [2:0]               ex_funct3;
    logic                     ex_funct7_5;
    logic                     ex_reg_write;
    logic                     ex_mem_read;
    logic                     ex_mem_write;
    logic                     ex_alu_src;
    logic                     ex_branch;
    logic                     ex_jump;

    modport master (
        output if_valid, if_instr, if_pc, flush,
        output rd1, rd2,
        output wb_RegWrite, wb_wa, wb_wd,
        output ex_ready,
        input  if_ready, ra1, ra2,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
        input  ex_opcode, ex_funct3, ex_funct7_5,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_jump
    );

    modport slave (
        input  if_valid, if_instr, if_pc, flush,
        input  rd1, rd2,
        input  wb_RegWrite, wb_wa, wb_wd,
        input  ex_ready,
        output if_ready, ra1, ra2,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
        output ex_opcode, ex_funct3, ex_funct7_5,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_jump
    );
endinterface

// File: rtl/id_ex_stage.sv
// RV64I decode stage and ID/EX pipeline register with writeback bypass,
// load-use bubble insertion, EX back-pressure hold and flush.
module id_ex_stage #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0]              instr;
    logic [6:0]               opcode;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic [2:0]               funct3;
    logic                     funct7_5;

    assign instr    = bus.if_instr;
    assign opcode   = instr[6:0];
    assign rd       = ADDRESS_WIDTH'(instr[11:7]);
    assign funct3   = instr[14:12];
    assign rs1      = ADDRESS_WIDTH'(instr[19:15]);
    assign rs2      = ADDRESS_WIDTH'(instr[24:20]);
    assign funct7_5 = instr[30];

    assign bus.ra1 = rs1;
    assign bus.ra2 = rs2;

    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_b;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] imm_j;

    assign imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign imm_u = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};

    logic [DATA_WIDTH-1:0] imm;
    logic                  dec_reg_write;
    logic                  dec_mem_read;
    logic                  dec_mem_write;
    logic                  dec_alu_src;
    logic                  dec_branch;
    logic                  dec_jump;
    logic                  use_rs1;
    logic                  use_rs2;

    always_comb begin
        imm           = '0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_alu_src   = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        use_rs1       = 1'b1;
        use_rs2       = 1'b0;
        case (opcode)
            OP_LOAD: begin
                imm           = imm_i;
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OP_IMM, OP_IMM32: begin
                imm           = imm_i;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OP_JALR: begin
                imm           = imm_i;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_jump      = 1'b1;
            end
            OP_STORE: begin
                imm           = imm_s;
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                imm           = imm_b;
                dec_branch    = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm           = imm_u;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                use_rs1       = 1'b0;
            end
            OP_JAL: begin
                imm           = imm_j;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_jump      = 1'b1;
                use_rs1       = 1'b0;
            end
            OP_REG, OP_REG32: begin
                dec_reg_write = 1'b1;
                use_rs2       = 1'b1;
            end
            default: begin
                imm = '0;
            end
        endcase
        // Writes to x0 are architecturally discarded, so never flag them.
        if (rd == '0) begin
            dec_reg_write = 1'b0;
        end
    end

    // The regfile only shows a write on the following cycle, so bypass the writeback port.
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    always_comb begin
        rs1_data = bus.rd1;
        if (rs1 == '0) begin
            rs1_data = '0;
        end else if (bus.wb_RegWrite && (bus.wb_wa == rs1)) begin
            rs1_data = bus.wb_wd;
        end
    end

    always_comb begin
        rs2_data = bus.rd2;
        if (rs2 == '0) begin
            rs2_data = '0;
        end else if (bus.wb_RegWrite && (bus.wb_wa == rs2)) begin
            rs2_data = bus.wb_wd;
        end
    end

    logic                     ex_valid;
    logic [DATA_WIDTH-1:0]    ex_pc;
    logic [DATA_WIDTH-1:0]    ex_rs1_data;
    logic [DATA_WIDTH-1:0]    ex_rs2_data;
    logic [DATA_WIDTH-1:0]    ex_imm;
    logic [ADDRESS_WIDTH-1:0] ex_rd;
    logic [6:0]               ex_opcode;
    logic [2:0]               ex_funct3;
    logic                     ex_funct7_5;
    logic                     ex_reg_write;
    logic                     ex_mem_read;
    logic                     ex_mem_write;
    logic                     ex_alu_src;
    logic                     ex_branch;
    logic                     ex_jump;

    logic hold;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    assign hold     = ex_valid && !bus.ex_ready;
    assign rs1_hit  = use_rs1 && (ex_rd == rs1);
    assign rs2_hit  = use_rs2 && (ex_rd == rs2);
    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit)
                      && bus.if_valid;

    assign bus.if_ready = !reset && (bus.flush || (!hold && !load_use));

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_opcode    <= '0;
            ex_funct3    <= '0;
            ex_funct7_5  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_alu_src   <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
        end else if (bus.flush || (!hold && load_use)) begin
            // Killed slot or bubble: clear every side-effecting control bit.
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
        end else if (!hold) begin
            ex_valid     <= bus.if_valid;
            ex_pc        <= bus.if_pc;
            ex_rs1_data  <= rs1_data;
            ex_rs2_data  <= rs2_data;
            ex_imm       <= imm;
            ex_rd        <= rd;
            ex_opcode    <= opcode;
            ex_funct3    <= funct3;
            ex_funct7_5  <= funct7_5;
            ex_reg_write <= dec_reg_write && bus.if_valid;
            ex_mem_read  <= dec_mem_read && bus.if_valid;
            ex_mem_write <= dec_mem_write && bus.if_valid;
            ex_alu_src   <= dec_alu_src;
            ex_branch    <= dec_branch && bus.if_valid;
            ex_jump      <= dec_jump && bus.if_valid;
        end
    end

    assign bus.ex_valid     = ex_valid;
    assign bus.ex_pc        = ex_pc;
    assign bus.ex_rs1_data  = ex_rs1_data;
    assign bus.ex_rs2_data  = ex_rs2_data;
    assign bus.ex_imm       = ex_imm;
    assign bus.ex_rd        = ex_rd;
    assign bus.ex_opcode    = ex_opcode;
    assign bus.ex_funct3    = ex_funct3;
    assign bus.ex_funct7_5  = ex_funct7_5;
    assign bus.ex_reg_write = ex_reg_write;
    assign bus.ex_mem_read  = ex_mem_read;
    assign bus.ex_mem_write = ex_mem_write;
    assign bus.ex_alu_src   = ex_alu_src;
    assign bus.ex_branch    = ex_branch;
    assign bus.ex_jump      = ex_jump;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected ID/EX contents are queued as each
// instruction is driven and checked when EX takes it.
module tb_id_ex_stage;
    localparam int DW = 64;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();
    id_ex_stage #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        as;
        logic        br;
        logic        j;
    } ex_t;

    ex_t sb[$];
    int  checks = 0;
    int  passes = 0;
    int  fails  = 0;

    task automatic check(input string tag, input logic [319:0] o, input logic [319:0] e);
        checks++;
        assert (o === e) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic ex_t mk(input logic [63:0] pc, rs1, rs2, imm, input logic [4:0] rd,
                               input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, rw, mr, mw, as, br, j);
        ex_t r;
        r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.rd = rd; r.op = op; r.f3 = f3;
        r.f7 = f7; r.rw = rw; r.mr = mr; r.mw = mw; r.as = as; r.br = br; r.j = j;
        return r;
    endfunction

    function automatic ex_t obs();
        ex_t r;
        r.pc = bus.ex_pc; r.rs1 = bus.ex_rs1_data; r.rs2 = bus.ex_rs2_data; r.imm = bus.ex_imm;
        r.rd = bus.ex_rd; r.op = bus.ex_opcode; r.f3 = bus.ex_funct3; r.f7 = bus.ex_funct7_5;
        r.rw = bus.ex_reg_write; r.mr = bus.ex_mem_read; r.mw = bus.ex_mem_write;
        r.as = bus.ex_alu_src; r.br = bus.ex_branch; r.j = bus.ex_jump;
        return r;
    endfunction

    // Scoreboard consumer: one entry per transfer into EX.
    always @(negedge clk) begin
        ex_t e;
        if (!reset && bus.ex_valid && bus.ex_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 320'(sb.size()), 320'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("ex_out pc=%0h", e.pc), obs(), e);
            end
        end
    end

    // Called just after a posedge; returns just after the posedge that accepted the instruction.
    task automatic drive(input logic [31:0] ins, input logic [63:0] pc, r1, r2,
                         input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input ex_t e, input bit push);
        bit accepted;
        bus.if_valid = 1'b1; bus.if_instr = ins; bus.if_pc = pc;
        bus.rd1 = r1; bus.rd2 = r2;
        bus.wb_RegWrite = we; bus.wb_wa = wa; bus.wb_wd = wd;
        if (push) sb.push_back(e);
        accepted = 1'b0;
        for (int k = 0; k < 20 && !accepted; k++) begin
            @(negedge clk);
            if (bus.if_ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        check($sformatf("accept pc=%0h", pc), 320'(accepted), 320'd1);
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        ex_t e_add2;
        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.flush = 1'b0;
        bus.rd1 = '0; bus.rd2 = '0; bus.wb_RegWrite = 1'b0; bus.wb_wa = '0; bus.wb_wd = '0;
        bus.ex_ready = 1'b1;

        @(negedge clk);
        check("ready_in_reset", 320'(bus.if_ready), 320'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_valid", 320'(bus.ex_valid), 320'd0);
        check("reset_fields", obs(), '0);
        check("ready_after_reset", 320'(bus.if_ready), 320'd1);
        @(posedge clk); #1;

        // Back-to-back stream; x0 source ignores rd1 and a writeback aimed at x0.
        drive(32'hFFF00293, 64'h100, 64'h1234, 64'h0, 1'b1, 5'd0, 64'hDEAD,
              mk(64'h100, 64'h0, 64'h0, ONES, 5'd5, 7'h13, 3'd0, 1, 1, 0, 0, 1, 0, 0), 1);
        drive(32'h002081B3, 64'h104, 64'h5, 64'h7, 1'b1, 5'd2, 64'h9,
              mk(64'h104, 64'h5, 64'h9, 64'h0, 5'd3, 7'h33, 3'd0, 0, 1, 0, 0, 0, 0, 0), 1);
        drive(32'hFFDFF0EF, 64'h108, 64'hA, 64'hB, 1'b0, 5'd0, 64'h0,
              mk(64'h108, 64'hA, 64'hB, ONES - 64'd3, 5'd1, 7'h6F, 3'd7, 1, 1, 0, 0, 1, 0, 1), 1);
        drive(32'h00209863, 64'h10C, 64'h11, 64'h22, 1'b1, 5'd1, 64'h55,
              mk(64'h10C, 64'h55, 64'h22, 64'h10, 5'd16, 7'h63, 3'd1, 0, 0, 0, 0, 0, 1, 0), 1);
        drive(32'h80000537, 64'h110, 64'h99, 64'h0, 1'b0, 5'd0, 64'h0,
              mk(64'h110, 64'h0, 64'h0, 64'hFFFF_FFFF_8000_0000, 5'd10, 7'h37, 3'd0,
                 0, 1, 0, 0, 1, 0, 0), 1);
        drive(32'h0000B203, 64'h114, 64'h40, 64'h3, 1'b0, 5'd0, 64'h0,
              mk(64'h114, 64'h40, 64'h0, 64'h0, 5'd4, 7'h03, 3'd3, 0, 1, 1, 0, 1, 0, 0), 1);

        // ADD x6,x4,x4 right behind LD x4: one stall cycle and one bubble.
        bus.if_instr = 32'h00420333; bus.if_pc = 64'h118; bus.rd1 = 64'h77; bus.rd2 = 64'h77;
        sb.push_back(mk(64'h118, 64'h77, 64'h77, 64'h0, 5'd6, 7'h33, 3'd0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("lu_stall_ready", 320'(bus.if_ready), 320'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lu_bubble_valid", 320'(bus.ex_valid), 320'd0);
        check("lu_bubble_rw", 320'({bus.ex_reg_write, bus.ex_mem_read}), 320'd0);
        check("lu_resume_ready", 320'(bus.if_ready), 320'd1);
        @(posedge clk); #1;

        // EX back-pressure for three cycles.
        e_add2 = mk(64'h200, 64'h1, 64'h2, 64'h0, 5'd3, 7'h33, 3'd0, 0, 1, 0, 0, 0, 0, 0);
        drive(32'h002081B3, 64'h200, 64'h1, 64'h2, 1'b0, 5'd0, 64'h0, e_add2, 1);
        bus.ex_ready = 1'b0;
        bus.if_instr = 32'h00508393; bus.if_pc = 64'h204; bus.rd1 = 64'h10; bus.rd2 = 64'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("hold_ready c%0d", c), 320'(bus.if_ready), 320'd0);
            check($sformatf("hold_stable c%0d", c), {obs(), bus.ex_valid}, {e_add2, 1'b1});
            @(posedge clk); #1;
        end
        bus.ex_ready = 1'b1;
        drive(32'h00508393, 64'h204, 64'h10, 64'h0, 1'b0, 5'd0, 64'h0,
              mk(64'h204, 64'h10, 64'h0, 64'h5, 5'd7, 7'h13, 3'd0, 0, 1, 0, 0, 1, 0, 0), 1);
        bus.if_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;

        // Flush with a store parked in ID/EX and EX stalled.
        bus.ex_ready = 1'b0;
        drive(32'h0020B423, 64'h300, 64'h8, 64'h9, 1'b0, 5'd0, 64'h0, '0, 0);
        bus.flush = 1'b1;
        bus.if_instr = 32'h00508393; bus.if_pc = 64'h304;
        @(negedge clk);
        check("pre_flush_store", 320'({bus.ex_valid, bus.ex_mem_write}), 320'd3);
        check("flush_ready", 320'(bus.if_ready), 320'd1);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.if_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 320'(bus.ex_valid), 320'd0);
        check("flush_mem_write", 320'(bus.ex_mem_write), 320'd0);
        @(posedge clk); #1;

        // Reset while EX is stalled.
        drive(32'h002081B3, 64'h400, 64'h1, 64'h2, 1'b0, 5'd0, 64'h0, '0, 0);
        @(negedge clk);
        check("stall_ready", 320'(bus.if_ready), 320'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", 320'(bus.if_ready), 320'd0);
        @(posedge clk); #1;
        reset = 1'b0; bus.ex_ready = 1'b1; bus.if_valid = 1'b0;
        @(negedge clk);
        check("rst_stall_valid", 320'(bus.ex_valid), 320'd0);
        check("rst_stall_fields", obs(), '0);
        check("rst_stall_ready", 320'(bus.if_ready), 320'd1);
        @(posedge clk); #1;
        check("sb_drained", 320'(sb.size()), 320'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
